// File: rtl/acc_cmd_responder.sv
// Accelerator endpoint for the core cmd/resp link: decodes custom-0 instructions, runs ADD/XOR/ACC ops
// (plus an iterative shift-add MUL when ACC_MUL_EN is defined) and returns results tagged with rd.
module acc_cmd_responder #(
  parameter int         ACC_DATA_WIDTH     = 64,
  parameter int         ACC_INSTR_WIDTH    = 32,
  parameter int         ACC_REG_ADDR_WIDTH = 5,
  parameter logic [6:0] ACC_OPCODE         = 7'b0001011
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ACC_INSTR_WIDTH-1:0]    cmd_inst,
  input  logic [ACC_DATA_WIDTH-1:0]     cmd_rs1,
  input  logic [ACC_DATA_WIDTH-1:0]     cmd_rs2,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ACC_DATA_WIDTH-1:0]     resp_data,
  output logic [ACC_REG_ADDR_WIDTH-1:0] resp_rd,
  output logic                          cmd_err_o
);

  localparam logic [6:0] F_ADD    = 7'd0;
  localparam logic [6:0] F_XOR    = 7'd1;
  localparam logic [6:0] F_MUL    = 7'd2;
  localparam logic [6:0] F_ACC    = 7'd3;
  localparam logic [6:0] F_RDACC  = 7'd4;
  localparam logic [6:0] F_CLRACC = 7'd5;

`ifdef ACC_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
  localparam int CNT_W = $clog2(ACC_DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_DATA_WIDTH - 1);
`else
  typedef enum logic [1:0] {IDLE, RESP} state_t;
`endif

  state_t                          state_q, state_d;
  logic [ACC_DATA_WIDTH-1:0]       acc_q, acc_d, acc_next, op_result;
  logic [ACC_DATA_WIDTH-1:0]       resp_data_q, resp_data_d;
  logic [ACC_REG_ADDR_WIDTH-1:0]   resp_rd_q, resp_rd_d;
  logic                            cmd_ready_q, err_q, err_d;
  logic                            cmd_fire, cmd_illegal;

`ifdef ACC_MUL_EN
  logic [ACC_DATA_WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d, prod_sum;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      mul_xd_q, mul_xd_d;
`endif

  logic [6:0]                    funct7, opcode;
  logic                          xd;
  logic [ACC_REG_ADDR_WIDTH-1:0] rd;
  logic                          unused_inst_bits;

  assign funct7           = cmd_inst[31:25];
  assign xd               = cmd_inst[14];
  assign rd               = cmd_inst[7 +: ACC_REG_ADDR_WIDTH];
  assign opcode           = cmd_inst[6:0];
  assign unused_inst_bits = ^{cmd_inst[24:15], cmd_inst[13:12]};

  assign cmd_fire = cmd_valid && cmd_ready_q;

  // NOTE: every variable driven in an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    cmd_illegal = (opcode != ACC_OPCODE) || (funct7 > F_CLRACC);
`ifndef ACC_MUL_EN
    if (funct7 == F_MUL) cmd_illegal = 1'b1;
`endif
  end

  // Single-cycle results and the accumulator side effect of the presented command.
  always_comb begin
    op_result = '0;
    acc_next  = acc_q;
    case (funct7)
      F_ADD:    op_result = cmd_rs1 + cmd_rs2;
      F_XOR:    op_result = cmd_rs1 ^ cmd_rs2;
      F_ACC: begin
        acc_next  = acc_q + cmd_rs1;
        op_result = acc_next;
      end
      F_RDACC:  op_result = acc_q;
      F_CLRACC: begin
        acc_next  = '0;
        op_result = acc_q;
      end
      default:  ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    resp_data_d = resp_data_q;
    resp_rd_d   = resp_rd_q;
    err_d       = 1'b0;
`ifdef ACC_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    mul_xd_d = mul_xd_q;
    prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_illegal) begin
            err_d = 1'b1;
`ifdef ACC_MUL_EN
          end else if (funct7 == F_MUL) begin
            state_d   = MUL;
            mcand_d   = cmd_rs1;
            mplier_d  = cmd_rs2;
            prod_d    = '0;
            cnt_d     = '0;
            mul_xd_d  = xd;
            resp_rd_d = rd;
`endif
          end else begin
            acc_d = acc_next;
            if (xd) begin
              state_d     = RESP;
              resp_data_d = op_result;
              resp_rd_d   = rd;
            end
          end
        end
      end
`ifdef ACC_MUL_EN
      // One multiplier bit per cycle; the last partial sum goes straight into the response register.
      MUL: begin
        prod_d   = prod_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          if (mul_xd_q) begin
            state_d     = RESP;
            resp_data_d = prod_sum;
          end else begin
            state_d = IDLE;
          end
        end
      end
`endif
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      resp_data_q <= '0;
      resp_rd_q   <= '0;
      cmd_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      resp_data_q <= resp_data_d;
      resp_rd_q   <= resp_rd_d;
      cmd_ready_q <= (state_d == IDLE);
      err_q       <= err_d;
    end
  end

`ifdef ACC_MUL_EN
  // NOTE: multiplier working registers are not reset; they are always loaded on accept before use.
  always_ff @(posedge clk_i) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    prod_q   <= prod_d;
    cnt_q    <= cnt_d;
    mul_xd_q <= mul_xd_d;
  end
`endif

  assign cmd_ready  = cmd_ready_q;
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign cmd_err_o  = err_q;

endmodule
